inst_fetch_buffer: RTL and testbench
====================================

Name: inst_fetch_buffer

Overview:
- Instruction prefetch stage that sits directly upstream of the RV64IF core and supplies its 32-bit instruction input.
- Issues sequential word fetches to instruction memory over a req/ack handshake, one request outstanding at a time.
- Queues returned words with their PC in a small FIFO and hands them to the core over a valid/ready handshake.
- On a core redirect (branch or jump resolution), flushes the queue, discards any in-flight response and refetches from the new PC.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 64'h0, first fetch address after reset.

Ports:
- in_Clk  input  1  clock; all state updates on the rising edge.
- in_Rst  input  1  reset; synchronous and active-high.
- in_redirect  input  1  core requests a refetch from in_redirect_pc.
- in_redirect_pc  input  64  new fetch PC; bits [1:0] are ignored and forced to 0.
- in_inst_ready  input  1  core accepts out_inst this cycle.
- out_inst_valid  output  1  out_inst and out_inst_pc are valid.
- out_inst  output  32  instruction word at the FIFO head.
- out_inst_pc  output  64  PC of out_inst.
- out_mem_req  output  1  fetch request to instruction memory.
- out_mem_addr  output  64  fetch address; word aligned.
- in_mem_ack  input  1  memory returns in_mem_data this cycle; completes the request.
- in_mem_data  input  32  fetched word.

Behaviour:
- Reset (synchronous, active-high): fetch_pc = RESET_PC, FIFO empty, count = 0, state = IDLE. out_inst_valid = 0, out_mem_req = 0, out_mem_addr = RESET_PC, out_inst = 0, out_inst_pc = 0. Reset overrides every other input, including mid-request; a later ack for a request aborted by reset is ignored.
- Fetch FSM (registered state):
  - IDLE: if count < DEPTH and no redirect, go to REQ.
  - REQ: out_mem_req = 1 and out_mem_addr = fetch_pc, both held stable until ack.
    - On ack without redirect: push {fetch_pc, in_mem_data}, fetch_pc += 4 (64-bit wrap), then go to REQ again if free space remains after the push/pop, otherwise IDLE.
    - On redirect in the same cycle as ack: drop the data, go to IDLE.
    - On redirect without ack: go to DROP.
  - DROP: out_mem_req = 1 and out_mem_addr holds the old address, because the request is still open. On ack, discard the data and go to IDLE. A further redirect in DROP only updates fetch_pc.
- Space rule: in REQ, the slot for the outstanding word is reserved, so a push never finds the FIFO full. A pop in the same cycle as a push frees a slot for the next issue.
- Redirect (any state except reset): FIFO flushed (count = 0) and fetch_pc = {in_redirect_pc[63:2], 2'b00} at that edge. Any pop requested in the same cycle is ignored. out_inst_valid = 0 on the next cycle.
- Core side: out_inst_valid = (count != 0). out_inst and out_inst_pc come combinationally from the head entry. Pop when out_inst_valid & in_inst_ready & !in_redirect.
- Simultaneous push and pop: count is unchanged; head and tail pointers both advance modulo DEPTH.
- Latency:
  - Reset released at edge N: out_mem_req = 1 in the cycle after edge N+1, so one IDLE cycle.
  - Ack at edge M: out_inst_valid = 1 from edge M onward. Ack-to-valid is one cycle.
- A word is never duplicated or lost except words discarded by a redirect.

Optional Feature:
- FETCH_BYPASS_EN.
  - Defined: when the FIFO is empty, state is REQ, in_mem_ack = 1 and in_redirect = 0, out_inst_valid = 1 combinationally with out_inst = in_mem_data and out_inst_pc = fetch_pc. If in_inst_ready = 1, the word is consumed and not pushed; otherwise it is pushed as normal. Ack-to-consume latency is 0 cycles.
  - Undefined: no combinational path from the memory side to the core side; latency is as stated in Behaviour.

Test Plan:
- Reset, RESET_PC = 0x1000, memory acks every request the next cycle, in_inst_ready = 1 -> out_inst_pc sequence 0x1000, 0x1004, 0x1008, each with its memory word, no gaps after the first.
- in_inst_ready = 0 with DEPTH = 4 -> exactly 4 acks, then out_mem_req = 0 and count = 4. Raise ready for 1 cycle -> exactly 1 new request at 0x1010.
- Redirect to 0x2002 while REQ is waiting on 0x1008, ack 3 cycles later -> that ack's data is discarded, next request is at 0x2000, first delivered out_inst_pc = 0x2000.
- Redirect in the same cycle as ack and as a pop of a valid head -> nothing pushed, nothing popped, FIFO empty, out_inst_valid = 0 the next cycle.
- in_Rst asserted while REQ is outstanding, then the ack arrives during reset -> all outputs at their reset values, first post-reset request at RESET_PC.
- With FETCH_BYPASS_EN, empty FIFO, ack and ready in the same cycle -> out_inst_valid = 1 that cycle with out_inst = in_mem_data, count stays 0. Without the macro, valid rises one cycle later.

Source files
------------

// File: rtl/inst_fetch_buffer.sv
// Purpose: sequential instruction prefetch into a DEPTH-entry queue feeding the core; redirect flushes and refetches.
// Latency: one idle cycle after reset before the first request; ack to out_inst_valid is one cycle (zero with FETCH_BYPASS_EN).
// Backpressure: a fetch is issued only while a queue slot is free; one request open at a time, core pops on valid & ready.
module inst_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        in_Clk,
    input  logic        in_Rst,
    input  logic        in_redirect,
    input  logic [63:0] in_redirect_pc,
    input  logic        in_inst_ready,
    output logic        out_inst_valid,
    output logic [31:0] out_inst,
    output logic [63:0] out_inst_pc,
    output logic        out_mem_req,
    output logic [63:0] out_mem_addr,
    input  logic        in_mem_ack,
    input  logic [31:0] in_mem_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [63:0]   fetch_pc, drop_addr;
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count, count_nxt;
    logic [31:0]   inst_mem [DEPTH];
    logic [63:0]   pc_mem   [DEPTH];

    logic ack_req, push, pop, fifo_valid, bypass_take;

    assign fifo_valid = (count != '0);
    assign ack_req    = (state == REQ) && in_mem_ack;
    assign pop        = fifo_valid && in_inst_ready && !in_redirect;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    // Empty queue and a live response: hand the word straight to the core.
    assign bypass         = !fifo_valid && ack_req && !in_redirect;
    assign bypass_take    = bypass && in_inst_ready;
    assign out_inst_valid = fifo_valid || bypass;
    assign out_inst       = fifo_valid ? inst_mem[head] : (bypass ? in_mem_data : 32'h0);
    assign out_inst_pc    = fifo_valid ? pc_mem[head]   : (bypass ? fetch_pc    : 64'h0);
`else
    assign bypass_take    = 1'b0;
    assign out_inst_valid = fifo_valid;
    assign out_inst       = fifo_valid ? inst_mem[head] : 32'h0;
    assign out_inst_pc    = fifo_valid ? pc_mem[head]   : 64'h0;
`endif

    assign push      = ack_req && !in_redirect && !bypass_take;
    assign count_nxt = count + CW'(push) - CW'(pop);

    assign out_mem_req  = (state != IDLE);
    assign out_mem_addr = (state == DROP) ? drop_addr : fetch_pc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!in_redirect && (count < CW'(DEPTH))) state_nxt = REQ;
            REQ: begin
                if (in_mem_ack)
                    state_nxt = (!in_redirect && (count_nxt < CW'(DEPTH))) ? REQ : IDLE;
                else if (in_redirect)
                    state_nxt = DROP;
            end
            DROP: if (in_mem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            state <= state_nxt;
            // The aborted request stays open in DROP, so keep its address on the bus.
            if (state == REQ && state_nxt == DROP)
                drop_addr <= fetch_pc;
            if (in_redirect) begin
                fetch_pc <= in_redirect_pc & ~64'h3;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (ack_req)
                    fetch_pc <= fetch_pc + 64'd4;
                if (push)
                    tail <= tail + AW'(1);
                if (pop)
                    head <= head + AW'(1);
                count <= count_nxt;
            end
        end
    end

    always_ff @(posedge in_Clk) begin
        if (push) begin
            inst_mem[tail] <= in_mem_data;
            pc_mem[tail]   <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Randomized bench for inst_fetch_buffer against a queue-based reference model.
module tb_inst_fetch_buffer;
    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h1000;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        in_Rst, in_redirect, in_inst_ready, in_mem_ack;
    logic [63:0] in_redirect_pc;
    logic [31:0] in_mem_data;
    logic        out_inst_valid, out_mem_req;
    logic [31:0] out_inst;
    logic [63:0] out_inst_pc, out_mem_addr;

    always #5 clk = ~clk;

    inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .in_Clk         (clk),
        .in_Rst         (in_Rst),
        .in_redirect    (in_redirect),
        .in_redirect_pc (in_redirect_pc),
        .in_inst_ready  (in_inst_ready),
        .out_inst_valid (out_inst_valid),
        .out_inst       (out_inst),
        .out_inst_pc    (out_inst_pc),
        .out_mem_req    (out_mem_req),
        .out_mem_addr   (out_mem_addr),
        .in_mem_ack     (in_mem_ack),
        .in_mem_data    (in_mem_data)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: delivered-word queue plus the open-request bookkeeping.
    ent_t        q[$];
    bit          open, stale, rst_fresh, started;
    logic [63:0] fpc, oaddr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input int p_ack, input int p_rdy, input int p_redir);
        in_Rst        = rst;
        in_mem_ack    = (open || rst) && ($urandom_range(99) < p_ack);
        in_mem_data   = $urandom;
        in_inst_ready = ($urandom_range(99) < p_rdy);
        in_redirect   = ($urandom_range(99) < p_redir);
        if ($urandom_range(7) == 0)
            in_redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
        else
            in_redirect_pc = {$urandom, $urandom};
    endtask

    task automatic compare();
        bit   byp;
        ent_t h;
        byp = BYP && q.size() == 0 && open && !stale && in_mem_ack && !in_redirect;
        check("mem_req", out_mem_req, open);
        if (open)
            check("mem_addr", out_mem_addr, oaddr);
        check("inst_valid", out_inst_valid, (q.size() != 0) || byp);
        if (q.size() != 0) begin
            h = q[0];
            check("inst", out_inst, h.d);
            check("inst_pc", out_inst_pc, h.pc);
        end else if (byp) begin
            check("byp_inst", out_inst, in_mem_data);
            check("byp_pc", out_inst_pc, fpc);
        end
        if (rst_fresh) begin
            check("rst_inst", out_inst, 64'h0);
            check("rst_pc", out_inst_pc, 64'h0);
            check("rst_addr", out_mem_addr, RPC);
        end
    endtask

    task automatic update();
        int sz0;
        bit take;
        if (in_Rst) begin
            q.delete();
            open      = 0;
            stale     = 0;
            fpc       = RPC;
            rst_fresh = 1;
            return;
        end
        rst_fresh = 0;
        if (in_redirect) begin
            q.delete();
            if (open && in_mem_ack) begin
                open  = 0;
                stale = 0;
            end else if (open) begin
                stale = 1;
            end
            fpc = in_redirect_pc & ~64'h3;
        end else begin
            sz0  = q.size();
            take = BYP && sz0 == 0 && open && !stale && in_mem_ack && in_inst_ready;
            if (sz0 != 0 && in_inst_ready)
                void'(q.pop_front());
            if (open && in_mem_ack) begin
                if (stale) begin
                    open  = 0;
                    stale = 0;
                end else begin
                    if (!take)
                        q.push_back({fpc, in_mem_data});
                    fpc  = fpc + 64'd4;
                    open = (q.size() < DEPTH);
                end
            end else if (!open) begin
                open = (sz0 < DEPTH);
            end
        end
        if (open && !stale)
            oaddr = fpc;
    endtask

    task automatic cycle(input bit rst, input int p_ack, input int p_rdy, input int p_redir);
        @(negedge clk);
        drive(rst, p_ack, p_rdy, p_redir);
        #1;
        if (started)
            compare();
        @(posedge clk);
        update();
        started = 1;
    endtask

    initial begin
        in_Rst = 1'b1; in_redirect = 1'b0; in_redirect_pc = '0;
        in_inst_ready = 1'b0; in_mem_ack = 1'b0; in_mem_data = '0;
        open = 0; stale = 0; rst_fresh = 0; started = 0; fpc = RPC; oaddr = RPC;

        repeat (3) cycle(1, 0, 0, 0);
        // Streaming with an always-ready core and a memory acking every request.
        repeat (20) cycle(0, 100, 100, 0);
        // Core stalled: queue fills, fetching stops; then a single pop.
        repeat (12) cycle(0, 100, 0, 0);
        cycle(0, 100, 100, 0);
        repeat (6) cycle(0, 100, 0, 0);
        // Request left open, then reset with acks landing during reset.
        repeat (4) cycle(0, 0, 100, 0);
        repeat (3) cycle(1, 100, 50, 20);
        repeat (8) cycle(0, 100, 100, 0);
        // Redirect while a request waits unacked, then a late ack.
        repeat (3) cycle(0, 0, 100, 0);
        cycle(0, 0, 100, 100);
        repeat (2) cycle(0, 0, 100, 0);
        repeat (10) cycle(0, 100, 100, 0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(199) == 0)
                repeat (2) cycle(1, 50, 50, 10);
            else if (i % 500 < 100)
                cycle(0, 90, 95, 15);
            else
                cycle(0, 45, 60, 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
